// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding, default widths and saturation helpers for mac_vec_q.
package mac_pkg;

    localparam int LANES_D  = 4;
    localparam int DATA_W_D = 8;
    localparam int ACC_W_D  = 32;
    localparam int OUT_W_D  = 8;
    localparam int LEN_W_D  = 8;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, QUANT, OUT} state_e;

    function automatic logic signed [63:0] clamp(input logic signed [63:0] v, lo, hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    // Widths up to 63 bits; callers cast the result down to the target width.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return clamp(v, -hi - 64'sd1, hi);
    endfunction

endpackage

// File: rtl/mac_vec_q_if.sv
// mac_vec_q_if: control, operand and result handshake bundle for mac_vec_q.
interface mac_vec_q_if import mac_pkg::*; #(
    parameter int LANES  = LANES_D,
    parameter int DATA_W = DATA_W_D,
    parameter int ACC_W  = ACC_W_D,
    parameter int OUT_W  = OUT_W_D,
    parameter int LEN_W  = LEN_W_D
);
    logic                      start;
    logic [LEN_W-1:0]          len;
    logic [4:0]                shift;
    logic signed [ACC_W-1:0]   bias;
    logic                      busy;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_a;
    logic [LANES*DATA_W-1:0]   in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic signed [ACC_W-1:0]   out_acc;
    logic                      overflow;

    modport master (
        output start, len, shift, bias, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_data, out_acc, overflow
    );

    modport slave (
        input  start, len, shift, bias, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_data, out_acc, overflow
    );
endinterface

// File: rtl/mac_lane_tree.sv
// mac_lane_tree: LANES signed multipliers followed by a registered reduction, 2-cycle latency.
module mac_lane_tree #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [LANES*DATA_W-1:0]  a_i,
    input  logic [LANES*DATA_W-1:0]  b_i,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic signed [SUM_W-1:0]  sum_o
);
    localparam int P_W = 2 * DATA_W;

    logic signed [P_W-1:0]   prod_q [LANES];
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic                    p_valid_q, s_valid_q;

    always_comb begin
        sum_d = '0;
        for (int l = 0; l < LANES; l++) sum_d = sum_d + SUM_W'(prod_q[l]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            p_valid_q <= valid_i;
            s_valid_q <= p_valid_q;
        end
        for (int l = 0; l < LANES; l++)
            prod_q[l] <= $signed(a_i[l*DATA_W +: DATA_W]) * $signed(b_i[l*DATA_W +: DATA_W]);
        sum_q <= sum_d;
    end

    assign valid_o = s_valid_q;
    assign busy_o  = p_valid_q || s_valid_q;
    assign sum_o   = sum_q;
endmodule

// File: rtl/mac_vec_q.sv
// mac_vec_q: LANES-wide signed dot-product accumulator with bias, round-half-up shift and saturation.
module mac_vec_q import mac_pkg::*; #(
    parameter int LANES  = LANES_D,
    parameter int DATA_W = DATA_W_D,
    parameter int ACC_W  = ACC_W_D,
    parameter int OUT_W  = OUT_W_D,
    parameter int LEN_W  = LEN_W_D
) (
    input logic clk,
    input logic rst,
    mac_vec_q_if.slave io
);
    localparam int SUM_W = 2 * DATA_W + $clog2(LANES);

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d, cnt_q, cnt_d;
    logic [4:0]              shift_q, shift_d;
    logic signed [ACC_W-1:0] bias_q, bias_d, acc_q, acc_d, out_acc_q, out_acc_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    ovf_q, ovf_d;
    logic                    beat, tree_valid, tree_busy;
    logic signed [SUM_W-1:0] tree_sum;
    logic signed [63:0]      acc_full, acc_sat, b_full, b_sat, rnd, r_full, r_sat;

    assign io.in_ready  = state_q == ACCUM && cnt_q < len_q;
    assign beat         = io.in_valid && io.in_ready;
    assign io.busy      = state_q != IDLE;
    assign io.out_valid = state_q == OUT;
    assign io.out_data  = out_data_q;
    assign io.out_acc   = out_acc_q;
    assign io.overflow  = ovf_q;

    mac_lane_tree #(.LANES(LANES), .DATA_W(DATA_W), .SUM_W(SUM_W)) u_tree (
        .clk     (clk),
        .rst     (rst),
        .valid_i (beat),
        .a_i     (io.in_a),
        .b_i     (io.in_b),
        .valid_o (tree_valid),
        .busy_o  (tree_busy),
        .sum_o   (tree_sum)
    );

    // Saturating datapath evaluated at 64 bits, then narrowed.
    assign acc_full = 64'(acc_q) + 64'(tree_sum);
    assign acc_sat  = sat_w(acc_full, ACC_W);
    assign b_full   = 64'(acc_q) + 64'(bias_q);
    assign b_sat    = sat_w(b_full, ACC_W);
    assign rnd      = shift_q == 5'd0 ? 64'sd0 : 64'sd1 <<< (shift_q - 5'd1);
    assign r_full   = b_sat + rnd;
    assign r_sat    = sat_w(r_full, ACC_W);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        shift_d    = shift_q;
        bias_d     = bias_q;
        cnt_d      = cnt_q;
        acc_d      = tree_valid ? ACC_W'(acc_sat) : acc_q;
        ovf_d      = ovf_q || (tree_valid && acc_sat != acc_full);
        out_data_d = out_data_q;
        out_acc_d  = out_acc_q;
        case (state_q)
            IDLE: if (io.start && io.len != '0) begin
                len_d   = io.len;
                shift_d = io.shift;
                bias_d  = io.bias;
                cnt_d   = '0;
                acc_d   = '0;
                ovf_d   = 1'b0;
                state_d = ACCUM;
            end
            ACCUM: if (beat) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_d == len_q ? DRAIN : ACCUM;
            end
            DRAIN: state_d = tree_busy ? DRAIN : QUANT;
            QUANT: begin
                out_acc_d  = ACC_W'(b_sat);
                out_data_d = OUT_W'(sat_w(r_sat >>> shift_q, OUT_W));
                ovf_d      = ovf_q || b_sat != b_full || r_sat != r_full;
                state_d    = OUT;
            end
            OUT: state_d = io.out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            shift_q    <= '0;
            bias_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_acc_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            bias_q     <= bias_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_acc_q  <= out_acc_d;
        end
    end
endmodule

// File: tb/tb_mac_vec_q.sv
// tb_mac_vec_q: table-driven, hand-written and randomized checks of mac_vec_q against an arithmetic model.
module tb_mac_vec_q;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_vec_q_if m0 ();
    mac_vec_q_if #(.ACC_W(16)) m1 ();

    mac_vec_q u0 (.clk(clk), .rst(rst), .io(m0));
    mac_vec_q #(.ACC_W(16)) u1 (.clk(clk), .rst(rst), .io(m1));

    typedef struct {
        int          len;
        int          sh;
        longint      bias;
        logic [31:0] a;
        logic [31:0] b;
        longint      eacc;
        longint      edata;
        bit          eovf;
    } vec_t;

    int          n_run, n_fail;
    logic [31:0] qa[$], qb[$];
    longint      got_acc, got_data;
    bit          got_ovf;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Dot product over queued beats, then bias, rounding and clamping straight from the arithmetic rules.
    function automatic void model(input int len, input int sh, input longint bias, input int accw,
                                  output longint eacc, output longint edata, output bit eovf);
        longint hi, lo, acc, s, v;
        logic [31:0] a, b;
        hi = (64'sd1 <<< (accw - 1)) - 1;
        lo = -hi - 1;
        acc = 0;
        eovf = 0;
        for (int i = 0; i < len; i++) begin
            a = qa[i];
            b = qb[i];
            s = 0;
            for (int l = 0; l < 4; l++) s += longint'($signed(a[l*8 +: 8])) * longint'($signed(b[l*8 +: 8]));
            acc += s;
            if (acc > hi) begin acc = hi; eovf = 1; end
            if (acc < lo) begin acc = lo; eovf = 1; end
        end
        v = acc + bias;
        if (v > hi) begin v = hi; eovf = 1; end
        if (v < lo) begin v = lo; eovf = 1; end
        eacc = v;
        if (sh > 0) begin
            v += 64'sd1 <<< (sh - 1);
            if (v > hi) begin v = hi; eovf = 1; end
        end
        v = v >>> sh;
        edata = v > 127 ? 127 : v < -128 ? -128 : v;
    endfunction

    // Entered at the negedge following the final accept on m0.
    task automatic finish_out(input string nm, input int stall);
        int  k;
        bit  stable;
        k = 0;
        while (!m0.out_valid && k < 20) begin @(negedge clk); k++; end
        chk({nm, " latency"}, k, 4);
        got_acc  = m0.out_acc;
        got_data = m0.out_data;
        got_ovf  = m0.overflow;
        stable = 1;
        repeat (stall) begin
            @(negedge clk);
            if (!m0.out_valid || m0.out_acc != got_acc || m0.out_data != got_data) stable = 0;
        end
        if (stall > 0) chk({nm, " stall stable"}, stable, 1);
        m0.out_ready = 1'b1;
        @(negedge clk);
        m0.out_ready = 1'b0;
        chk({nm, " out_valid drop"}, m0.out_valid, 0);
        chk({nm, " idle after out"}, m0.busy, 0);
    endtask

    task automatic run_seq(input string nm, input int len, input int sh, input longint bias,
                           input int gap, input int stall);
        int k;
        @(negedge clk);
        m0.start = 1'b1;
        m0.len   = 8'(len);
        m0.shift = 5'(sh);
        m0.bias  = 32'(bias);
        @(negedge clk);
        m0.start = 1'b0;
        chk({nm, " busy"}, m0.busy, 1);
        for (int i = 0; i < len; i++) begin
            m0.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            m0.in_valid = 1'b1;
            m0.in_a = qa[i];
            m0.in_b = qb[i];
            k = 0;
            while (!m0.in_ready && k < 8) begin @(negedge clk); k++; end
            if (m0.in_ready !== 1'b1) chk({nm, " in_ready"}, m0.in_ready, 1);
            @(negedge clk);
        end
        chk({nm, " in_ready after last"}, m0.in_ready, 0);
        m0.in_valid = 1'b0;
        finish_out(nm, stall);
    endtask

    vec_t   tbl[7];
    longint eacc, edata;
    bit     eovf, seen;
    int     len, sh, k;
    longint bias;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b1;
        {m0.start, m0.len, m0.shift, m0.bias, m0.in_valid, m0.in_a, m0.in_b, m0.out_ready} = '0;
        {m1.start, m1.len, m1.shift, m1.bias, m1.in_valid, m1.in_a, m1.in_b, m1.out_ready} = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", m0.busy, 0);
        chk("reset in_ready", m0.in_ready, 0);
        chk("reset out_valid", m0.out_valid, 0);
        chk("reset overflow", m0.overflow, 0);
        chk("reset out_data", m0.out_data, 0);
        chk("reset out_acc", m0.out_acc, 0);
        rst = 1'b0;

        tbl[0] = '{1, 0, 0, 32'h02020202, 32'h03030303, 24, 24, 0};
        tbl[1] = '{3, 10, 0, 32'h7f7f7f7f, 32'h7f7f7f7f, 193548, 127, 0};
        tbl[2] = '{1, 1, 0, 32'h000000ff, 32'h00000003, -3, -1, 0};
        tbl[3] = '{1, 0, -125, 32'h000000ff, 32'h00000003, -128, -128, 0};
        tbl[4] = '{2, 4, 100, 32'h80808080, 32'h80808080, 131172, 127, 0};
        tbl[5] = '{2, 3, 5, 32'h05fb0203, 32'hf9070402, -107, -13, 0};
        tbl[6] = '{1, 0, 64'h7fffffff, 32'h02020202, 32'h02020202, 2147483647, 127, 1};
        foreach (tbl[i]) begin
            qa.delete();
            qb.delete();
            for (int j = 0; j < tbl[i].len; j++) begin qa.push_back(tbl[i].a); qb.push_back(tbl[i].b); end
            run_seq($sformatf("tbl%0d", i), tbl[i].len, tbl[i].sh, tbl[i].bias, i % 3, i % 4);
            chk($sformatf("tbl%0d out_acc", i), got_acc, tbl[i].eacc);
            chk($sformatf("tbl%0d out_data", i), got_data, tbl[i].edata);
            chk($sformatf("tbl%0d overflow", i), got_ovf, tbl[i].eovf);
        end

        qa = '{32'h01020304, 32'hfffefdfc, 32'h7f80017f, 32'h10203040};
        qb = '{32'h05060708, 32'h01010101, 32'h7f7f7f7f, 32'hf0e0d0c0};
        model(4, 2, 7, 32, eacc, edata, eovf);
        run_seq("gaps", 4, 2, 7, 2, 5);
        chk("gaps out_acc", got_acc, eacc);
        chk("gaps out_data", got_data, edata);

        @(negedge clk);
        m0.start = 1'b1;
        m0.len   = 8'd0;
        @(negedge clk);
        m0.start = 1'b0;
        chk("len0 busy", m0.busy, 0);
        chk("len0 in_ready", m0.in_ready, 0);

        m0.start = 1'b1;
        m0.len   = 8'd2;
        m0.shift = 5'd0;
        m0.bias  = '0;
        @(negedge clk);
        m0.start    = 1'b0;
        m0.in_a     = 32'h01010101;
        m0.in_b     = 32'h01010101;
        m0.in_valid = 1'b1;
        @(negedge clk);
        m0.in_valid = 1'b0;
        m0.start    = 1'b1;
        m0.len      = 8'd5;
        m0.bias     = 32'd1000;
        @(negedge clk);
        m0.start    = 1'b0;
        m0.in_valid = 1'b1;
        @(negedge clk);
        m0.in_valid = 1'b0;
        finish_out("restart", 0);
        chk("restart out_acc", got_acc, 8);
        chk("restart out_data", got_data, 8);

        @(negedge clk);
        m1.start = 1'b1;
        m1.len   = 8'd3;
        m1.in_a  = 32'h7f7f7f7f;
        m1.in_b  = 32'h7f7f7f7f;
        @(negedge clk);
        m1.start    = 1'b0;
        m1.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        m1.in_valid = 1'b0;
        k = 0;
        while (!m1.out_valid && k < 20) begin @(negedge clk); k++; end
        chk("acc16 latency", k, 4);
        chk("acc16 out_acc", m1.out_acc, 32767);
        chk("acc16 out_data", m1.out_data, 127);
        chk("acc16 overflow", m1.overflow, 1);
        m1.out_ready = 1'b1;
        @(negedge clk);
        m1.out_ready = 1'b0;
        m1.start = 1'b1;
        m1.len   = 8'd1;
        @(negedge clk);
        m1.start = 1'b0;
        chk("acc16 overflow cleared", m1.overflow, 0);
        m1.in_a     = 32'h01010101;
        m1.in_b     = 32'h01010101;
        m1.in_valid = 1'b1;
        @(negedge clk);
        m1.in_valid = 1'b0;
        k = 0;
        while (!m1.out_valid && k < 20) begin @(negedge clk); k++; end
        chk("acc16 second out_acc", m1.out_acc, 4);
        chk("acc16 second overflow", m1.overflow, 0);
        m1.out_ready = 1'b1;
        @(negedge clk);
        m1.out_ready = 1'b0;

        m0.start = 1'b1;
        m0.len   = 8'd5;
        m0.bias  = '0;
        @(negedge clk);
        m0.start    = 1'b0;
        m0.in_a     = 32'h03030303;
        m0.in_b     = 32'h03030303;
        m0.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        m0.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", m0.busy, 0);
        chk("rst in_ready", m0.in_ready, 0);
        chk("rst out_valid", m0.out_valid, 0);
        seen = 0;
        repeat (10) begin @(negedge clk); if (m0.out_valid) seen = 1; end
        chk("rst no output", seen, 0);
        qa = '{32'h01010101};
        qb = '{32'h01010101};
        run_seq("post rst", 1, 0, 0, 0, 0);
        chk("post rst out_data", got_data, 4);

        for (int t = 0; t < 24; t++) begin
            qa.delete();
            qb.delete();
            len = $urandom_range(1, 6);
            sh  = $urandom_range(0, 15);
            k   = $urandom_range(0, 2097152);
            bias = longint'(k) - 1048576;
            if (t % 6 == 5) bias = (t % 12 == 5) ? 64'sd2147483000 : -64'sd2147483000;
            for (int j = 0; j < len; j++) begin qa.push_back($urandom()); qb.push_back($urandom()); end
            model(len, sh, bias, 32, eacc, edata, eovf);
            run_seq($sformatf("rnd%0d", t), len, sh, bias, $urandom_range(0, 2), $urandom_range(0, 3));
            chk($sformatf("rnd%0d out_acc", t), got_acc, eacc);
            chk($sformatf("rnd%0d out_data", t), got_data, edata);
            chk($sformatf("rnd%0d overflow", t), got_ovf, eovf);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_vec_q.md
Name: mac_vec_q

Overview:
- Parametrised successor to the single-lane INT8/FP16 MAC: a LANES-wide signed-integer dot-product engine.
- Each accepted beat multiplies LANES operand pairs, reduces them with a registered adder tree, and accumulates over a runtime-programmed number of beats.
- At the end of the sequence it adds a bias and requantizes to OUT_W (round-half-up shift, then saturate).
- Sits between the operand buffers and the activation writeback path; valid/ready handshake on both sides.

Parameters:
LANES, 4, number of multiplier lanes per beat (power of 2, >=1)
DATA_W, 8, signed operand width per lane
ACC_W, 32, signed accumulator width (>= 2*DATA_W + clog2(LANES))
OUT_W, 8, signed requantized output width
LEN_W, 8, width of beat-count field (max sequence 2^LEN_W-1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a sequence; sampled only in IDLE
len  in  LEN_W  beats in sequence, latched on accepted start
shift  in  5  right-shift amount for requantization, latched on start
bias  in  ACC_W  signed bias added before shift, latched on start
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts beat this cycle
in_a  in  LANES*DATA_W  packed signed operands, lane 0 in LSBs
in_b  in  LANES*DATA_W  packed signed operands, lane 0 in LSBs
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  OUT_W  requantized saturated result
out_acc  out  ACC_W  raw accumulator plus bias, before shift
overflow  out  1  sticky: accumulator saturated during this sequence

Behaviour:
- Reset values:
  - State IDLE; in_ready=0, out_valid=0, busy=0, overflow=0.
  - out_data=0, out_acc=0; accumulator, beat counter and pipeline valids cleared.
- Reset mid-operation: any state returns to IDLE on the next edge; pipeline contents discarded; no partial result emitted.
- FSM:
  - IDLE: start=1 with len!=0 latches len/shift/bias, clears accumulator, beat counter and overflow -> ACCUM. start with len=0 is ignored (stay IDLE).
  - ACCUM: in_ready=1 while beat count < len. A beat is accepted when in_valid&in_ready at an edge. On acceptance of beat number len -> DRAIN. in_valid gaps are allowed, no timeout.
  - DRAIN: in_ready=0; waits until both pipeline valids are clear and the last accumulate is done (2 cycles after the final accept) -> QUANT.
  - QUANT: one cycle; registers out_acc and out_data -> OUT.
  - OUT: out_valid=1, out_data/out_acc held stable until out_ready=1; on that edge out_valid=0 -> IDLE.
- start outside IDLE is ignored; no queueing.
- Pipeline for a beat accepted at edge t:
  - t: LANES products (2*DATA_W signed) registered.
  - t+1: adder-tree sum registered, sign-extended to ACC_W.
  - t+2: accumulator updated.
- Latency: final beat accepted at edge t -> out_valid high after edge t+4 (DRAIN t+1..t+2, QUANT t+3). len=1 gives the same latency.
- Accumulate rule:
  - acc_next = acc + sum, saturated to the signed ACC_W range.
  - On saturation, set overflow; it stays set until the next start.
- Requantization in QUANT:
  - v = sat_ACC_W(acc + bias).
  - If shift>0: v = v + (1<<(shift-1)), saturated.
  - r = v >>> shift (arithmetic).
  - out_data = r clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_acc = sat_ACC_W(acc + bias); rounding constant not included.
  - Bias or rounding saturation also sets overflow.
- Product and sum arithmetic is exact; only the accumulator, bias and rounding adds saturate.

Decomposition:
- Shared package mac_pkg:
  - FSM state enum (IDLE, ACCUM, DRAIN, QUANT, OUT).
  - Signed saturate-to-width function and clamp function.
  - Default width constants.
- One sub-module: mac_lane_tree. LANES multipliers plus a registered reduction tree with 2-cycle latency and a valid pipe; parametrised on LANES/DATA_W.
- FSM, accumulator and requantizer stay in mac_vec_q.

Test Plan:
1. LANES=4, len=1, all a=2, b=3, bias=0, shift=0 -> out_data=24, out_acc=24, out_valid exactly 4 edges after accept, overflow=0.
2. len=3, all lanes a=b=127, shift=10, bias=0:
   - out_acc=193548; (193548+512)>>10=189 -> out_data=127 (clamped); overflow=0.
3. len=1, lane0 a=-1 b=3, others 0, bias=0, shift=1 -> out_acc=-3, out_data=-1 (round-half-up). Same stimulus with bias=-125, shift=0 -> out_acc=-128, out_data=-128.
4. len=4 with in_valid low for 2 cycles between beats and out_ready low for 5 cycles:
   - only 4 beats accepted; in_ready=0 after the 4th accept;
   - out_data/out_acc stable while stalled; IDLE the cycle after the out_ready handshake.
5. Accumulator saturation and start handling:
   - ACC_W=16, len=3, all lanes a=b=127 -> out_acc=32767, overflow=1, out_data=127.
   - Next start clears overflow.
   - start pulsed during ACCUM, and start with len=0 in IDLE, both have no effect.
6. Reset during ACCUM after 2 of 5 beats:
   - next cycle busy=0, in_ready=0, out_valid=0, no output ever emitted for that sequence;
   - a fresh len=1 sequence (a=b=1) returns out_data=4.
